scu_dsp_dma: RTL and testbench

// DSP DMA transfer engine, downstream of the DSP instruction decoder. Executes the
// DMA command issued by decode: moves TN0 words between the external D0 bus and
// one DSP data RAM bank (or program RAM), owns the RA0/WA0 address registers and

---
 rtl/scu_dsp_dma_pkg.sv | 29 ++
 rtl/scu_dsp_dma.sv | 145 ++++++++++++++
 tb/tb_scu_dsp_dma.sv | 523 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scu_dsp_dma_pkg.sv
// Shared types and helpers for the SCU DSP DMA engine.
package scu_dsp_dma_pkg;

  localparam int unsigned DMA_CNT_W = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_D0  = 3'd1,
    WR_RAM = 3'd2,
    RD_RAM = 3'd3,
    WR_D0  = 3'd4,
    FIN    = 3'd5
  } DMAState_t;

  typedef struct packed {
    logic       dir;
    logic [1:0] rams;
    logic       prgw;
    logic [2:0] addi;
    logic       hold;
  } DMAInst_t;

  // D0 word increment for an ADDI code: 0,1,2,4,...,64 words.
  function automatic logic [6:0] addi_inc(input logic [2:0] addi);
    if (addi == 3'd0) return 7'd0;
    return 7'd1 << (addi - 3'd1);
  endfunction

endpackage

// File: rtl/scu_dsp_dma.sv
// DSP DMA engine: moves TN0 words between the D0 bus and a DSP data/program RAM,
// owns RA0/WA0 and drives the T0 busy flag.
module scu_dsp_dma
  import scu_dsp_dma_pkg::*;
#(
  parameter int unsigned D0_AW  = 25,
  parameter int unsigned PRG_AW = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic              START,
  input  logic              DIR,
  input  logic [1:0]        RAMS,
  input  logic              PRGW,
  input  logic [2:0]        ADDI,
  input  logic              HOLD,
  input  logic [7:0]        CNT,
  input  logic [31:0]       D1_DATA,
  input  logic              RA0_WE,
  input  logic              WA0_WE,
  output logic              D0_REQ,
  output logic              D0_WE,
  output logic [D0_AW-1:0]  D0_ADDR,
  output logic [31:0]       D0_DO,
  input  logic [31:0]       D0_DI,
  input  logic              D0_ACK,
  output logic [3:0]        RAM_RD,
  output logic [3:0]        RAM_WE,
  output logic [31:0]       RAM_DO,
  input  logic [31:0]       RAM_DI,
  output logic [3:0]        CT_INC,
  output logic              PRG_WE,
  output logic [PRG_AW-1:0] PRG_ADDR,
  output logic              BUSY,
  output logic              DONE
);

  DMAState_t              state_q, state_d;
  DMAInst_t               inst_q;
  logic [DMA_CNT_W-1:0]   cnt_q;
  logic [D0_AW-1:0]       addr_q, ra0_q, wa0_q, addr_step, d1_addr;
  logic [PRG_AW-1:0]      prg_addr_q;
  logic [31:0]            data_q;
  logic                   rd_pend_q;
  logic                   last_word;
  logic                   unused_d1;

  assign d1_addr   = D1_DATA[D0_AW-1:0];
  assign unused_d1 = ^D1_DATA[31:D0_AW];
  assign addr_step = D0_AW'(addi_inc(inst_q.addi));
  assign last_word = (cnt_q == DMA_CNT_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = DIR ? RD_RAM : RD_D0;
      RD_D0:   if (D0_ACK) state_d = WR_RAM;
      WR_RAM:  state_d = last_word ? FIN : RD_D0;
      RD_RAM:  state_d = WR_D0;
      WR_D0:   if (D0_ACK) state_d = last_word ? FIN : RD_RAM;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle strobes are qualified by CE so a frozen cycle is never counted twice.
  always_comb begin
    D0_REQ = (state_q == RD_D0) || (state_q == WR_D0);
    D0_WE  = (state_q == WR_D0);
    RAM_RD = '0;
    RAM_WE = '0;
    CT_INC = '0;
    PRG_WE = 1'b0;
    DONE   = CE && (state_q == FIN);
    BUSY   = (state_q != IDLE);
    if (CE && state_q == RD_RAM) begin
      RAM_RD[inst_q.rams] = 1'b1;
      CT_INC[inst_q.rams] = 1'b1;
    end
    if (CE && state_q == WR_RAM) begin
      if (inst_q.prgw) begin
        PRG_WE = 1'b1;
      end else begin
        RAM_WE[inst_q.rams] = 1'b1;
        CT_INC[inst_q.rams] = 1'b1;
      end
    end
  end

  assign D0_ADDR  = addr_q;
  // RAM read data arrives in the first WR_D0 cycle; forward it until latched.
  assign D0_DO    = rd_pend_q ? RAM_DI : data_q;
  assign RAM_DO   = data_q;
  assign PRG_ADDR = prg_addr_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      inst_q     <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      ra0_q      <= '0;
      wa0_q      <= '0;
      prg_addr_q <= '0;
      data_q     <= '0;
      rd_pend_q  <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      rd_pend_q <= 1'b0;
      if (RA0_WE) ra0_q <= d1_addr;
      if (WA0_WE) wa0_q <= d1_addr;
      unique case (state_q)
        IDLE: if (START) begin
          inst_q     <= '{dir: DIR, rams: RAMS, prgw: PRGW & ~DIR, addi: ADDI, hold: HOLD};
          cnt_q      <= (CNT == 8'd0) ? DMA_CNT_W'(256) : {1'b0, CNT};
          prg_addr_q <= '0;
          if (DIR) addr_q <= WA0_WE ? d1_addr : wa0_q;
          else     addr_q <= RA0_WE ? d1_addr : ra0_q;
        end
        RD_D0: if (D0_ACK) data_q <= D0_DI;
        WR_RAM: begin
          addr_q <= addr_q + addr_step;
          cnt_q  <= cnt_q - DMA_CNT_W'(1);
          if (inst_q.prgw) prg_addr_q <= prg_addr_q + PRG_AW'(1);
        end
        RD_RAM: rd_pend_q <= 1'b1;
        WR_D0: begin
          if (rd_pend_q) data_q <= RAM_DI;
          if (D0_ACK) begin
            addr_q <= addr_q + addr_step;
            cnt_q  <= cnt_q - DMA_CNT_W'(1);
          end
        end
        FIN: if (!inst_q.hold) begin
          // Writeback wins over a D1 load issued in the same cycle.
          if (inst_q.dir) wa0_q <= addr_q;
          else            ra0_q <= addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scu_dsp_dma.sv
// Self-checking bench for scu_dsp_dma: D0 slave, RAM model and scoreboard queues.
module tb_scu_dsp_dma;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE = 1'b1;
  logic        START = 1'b0, DIR = 1'b0, PRGW = 1'b0, HOLD = 1'b0;
  logic [1:0]  RAMS = '0;
  logic [2:0]  ADDI = '0;
  logic [7:0]  CNT = '0;
  logic [31:0] D1_DATA = '0;
  logic        RA0_WE = 1'b0, WA0_WE = 1'b0;
  logic        D0_REQ, D0_WE;
  logic [24:0] D0_ADDR;
  logic [31:0] D0_DO;
  logic [31:0] D0_DI = '0;
  logic        D0_ACK = 1'b0;
  logic [3:0]  RAM_RD, RAM_WE, CT_INC;
  logic [31:0] RAM_DO;
  logic [31:0] RAM_DI = '0;
  logic        PRG_WE;
  logic [7:0]  PRG_ADDR;
  logic        BUSY, DONE;

  int tests_run = 0;
  int fails = 0;

  scu_dsp_dma dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START), .DIR(DIR), .RAMS(RAMS),
    .PRGW(PRGW), .ADDI(ADDI), .HOLD(HOLD), .CNT(CNT), .D1_DATA(D1_DATA),
    .RA0_WE(RA0_WE), .WA0_WE(WA0_WE), .D0_REQ(D0_REQ), .D0_WE(D0_WE),
    .D0_ADDR(D0_ADDR), .D0_DO(D0_DO), .D0_DI(D0_DI), .D0_ACK(D0_ACK),
    .RAM_RD(RAM_RD), .RAM_WE(RAM_WE), .RAM_DO(RAM_DO), .RAM_DI(RAM_DI),
    .CT_INC(CT_INC), .PRG_WE(PRG_WE), .PRG_ADDR(PRG_ADDR), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] d0_word(input logic [24:0] a);
    return 32'h5A00_0000 ^ {7'd0, a};
  endfunction

  // Scoreboard queues: exp_* pushed with stimulus, obs_* pushed by the monitors.
  logic [24:0] exp_addr[$], obs_addr[$];
  logic        exp_we[$], obs_we[$];
  logic [31:0] exp_data[$], obs_data[$], exp_ramwd[$], obs_ramwd[$];
  logic [7:0]  obs_prga[$];

  int ack_lat = 0;
  int wait_cnt = 0;
  int n_we[4], n_rd[4], n_ct[4];
  int n_prg = 0, n_done = 0, n_busy = 0, n_bad = 0;
  int rd_req_seq = 0, rd_done_seq = 0;

  // D0 slave and strobe monitors, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!D0_REQ) wait_cnt = 0;
    if (CE) begin
      if (D0_ACK) begin
        D0_ACK = 1'b0;
        wait_cnt = 0;
      end else if (D0_REQ) begin
        if (wait_cnt >= ack_lat) begin
          D0_ACK = 1'b1;
          D0_DI = d0_word(D0_ADDR);
          obs_addr.push_back(D0_ADDR);
          obs_we.push_back(D0_WE);
          obs_data.push_back(D0_DO);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (RAM_WE[b]) n_we[b]++;
      if (RAM_RD[b]) n_rd[b]++;
      if (CT_INC[b]) n_ct[b]++;
    end
    if ($countones(RAM_WE) > 1 || $countones(RAM_RD) > 1) n_bad++;
    if (|RAM_WE) obs_ramwd.push_back(RAM_DO);
    if (|RAM_RD) rd_req_seq++;
    if (PRG_WE) begin
      n_prg++;
      obs_prga.push_back(PRG_ADDR);
    end
    if (DONE) n_done++;
    if (BUSY) n_busy++;
  end

  // Data RAM answers a read strobe in the following cycle.
  always @(posedge CLK) begin
    #1;
    if (rd_done_seq != rd_req_seq) begin
      RAM_DI = 32'hC0DE_0000 + 32'(rd_req_seq - 1);
      rd_done_seq = rd_req_seq;
    end
  end

  task automatic issue(input logic dir, input logic [1:0] rams, input logic prgw,
                       input logic [2:0] addi, input logic hold, input logic [7:0] cnt);
    DIR = dir; RAMS = rams; PRGW = prgw; ADDI = addi; HOLD = hold; CNT = cnt;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic load_reg(input logic wa, input logic [31:0] v);
    D1_DATA = v; RA0_WE = ~wa; WA0_WE = wa;
    @(posedge CLK); #1;
    RA0_WE = 1'b0; WA0_WE = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (!BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  function automatic int sum4(input int a[4]);
    return a[0] + a[1] + a[2] + a[3];
  endfunction

  // Reads back RA0 (dir=0) or WA0 (dir=1) as the first address of a 1-word HOLD transfer.
  task automatic probe(input logic dir, output logic [24:0] a, output bit ok);
    obs_addr.delete(); obs_we.delete(); obs_data.delete(); obs_ramwd.delete();
    ack_lat = 0;
    issue(dir, 2'd0, 1'b0, 3'd0, 1'b1, 8'd1);
    wait_idle(50, ok);
    if (obs_addr.size() != 1) ok = 1'b0;
    a = ok ? obs_addr[0] : 25'h0;
    obs_addr.delete(); obs_we.delete(); obs_data.delete(); obs_ramwd.delete();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    tests_run++;
    if (D0_REQ !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got req=%b busy=%b done=%b required 0 0 0", D0_REQ, BUSY, DONE);
    end
    tests_run++;
    if (D0_ADDR !== 25'h0) begin
      fails++;
      $display("FAIL reset_addr: got %h required 0", D0_ADDR);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (RAM_WE !== 4'h0 || RAM_RD !== 4'h0 || CT_INC !== 4'h0 || PRG_WE !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: got we=%h rd=%h ct=%h prg=%b required zeros",
               RAM_WE, RAM_RD, CT_INC, PRG_WE);
    end
  endtask

  task automatic test_d0_to_ram();
    bit ok;
    logic [24:0] a;
    int b_we[4], b_ct[4], b_done;
    load_reg(1'b0, 32'h100);
    ack_lat = 2;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(25'h100 + 25'(i)); exp_we.push_back(1'b0); exp_data.push_back('0);
      exp_ramwd.push_back(d0_word(25'h100 + 25'(i)));
    end
    b_we = n_we; b_ct = n_ct; b_done = n_done;
    issue(1'b0, 2'd2, 1'b0, 3'd1, 1'b0, 8'd3);
    tests_run++;
    if (BUSY !== 1'b1) begin
      fails++;
      $display("FAIL d2r_busy: got %b required 1", BUSY);
    end
    wait_idle(200, ok);
    tests_run++;
    if (!ok || obs_addr.size() != 3) begin
      fails++;
      $display("FAIL d2r_count: got %0d accesses (ok=%0d) required 3", obs_addr.size(), ok);
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [24:0] ea, oa;
      logic ew, ow;
      logic [31:0] ed, od;
      ea = exp_addr.pop_front(); ew = exp_we.pop_front(); ed = exp_data.pop_front();
      oa = obs_addr.pop_front(); ow = obs_we.pop_front(); od = obs_data.pop_front();
      tests_run++;
      if (oa !== ea || ow !== ew) begin
        fails++;
        $display("FAIL d2r_access: got a=%h we=%b required a=%h we=%b (d=%h/%h)",
                 oa, ow, ea, ew, od, ed);
      end
    end
    while (exp_ramwd.size() > 0 && obs_ramwd.size() > 0) begin
      logic [31:0] e, o;
      e = exp_ramwd.pop_front(); o = obs_ramwd.pop_front();
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL d2r_ramdata: got %h required %h", o, e);
      end
    end
    tests_run++;
    if (n_we[2] - b_we[2] != 3 || sum4(n_we) - sum4(b_we) != 3 || n_ct[2] - b_ct[2] != 3
        || sum4(n_ct) - sum4(b_ct) != 3) begin
      fails++;
      $display("FAIL d2r_strobes: got we2=%0d ct2=%0d required 3 3",
               n_we[2] - b_we[2], n_ct[2] - b_ct[2]);
    end
    tests_run++;
    if (n_done - b_done != 1) begin
      fails++;
      $display("FAIL d2r_done: got %0d pulses required 1", n_done - b_done);
    end
    exp_addr.delete(); exp_we.delete(); exp_data.delete(); exp_ramwd.delete();
    probe(1'b0, a, ok);
    tests_run++;
    if (!ok || a !== 25'h103) begin
      fails++;
      $display("FAIL d2r_ra0: got %h required 103", a);
    end
  endtask

  task automatic test_ram_to_d0();
    bit ok;
    logic [24:0] a;
    int b_rd[4], b_ct[4], b_we[4], base;
    load_reg(1'b1, 32'h40);
    ack_lat = 1;
    base = rd_req_seq;
    exp_addr.push_back(25'h40); exp_we.push_back(1'b1);
    exp_data.push_back(32'hC0DE_0000 + 32'(base));
    exp_addr.push_back(25'h44); exp_we.push_back(1'b1);
    exp_data.push_back(32'hC0DE_0000 + 32'(base + 1));
    b_rd = n_rd; b_ct = n_ct; b_we = n_we;
    issue(1'b1, 2'd0, 1'b0, 3'd3, 1'b1, 8'd2);
    wait_idle(200, ok);
    tests_run++;
    if (!ok || obs_addr.size() != 2) begin
      fails++;
      $display("FAIL r2d_count: got %0d accesses (ok=%0d) required 2", obs_addr.size(), ok);
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [24:0] ea, oa;
      logic ew, ow;
      logic [31:0] ed, od;
      ea = exp_addr.pop_front(); ew = exp_we.pop_front(); ed = exp_data.pop_front();
      oa = obs_addr.pop_front(); ow = obs_we.pop_front(); od = obs_data.pop_front();
      tests_run++;
      if (oa !== ea || ow !== ew || od !== ed) begin
        fails++;
        $display("FAIL r2d_access: got a=%h we=%b d=%h required a=%h we=%b d=%h",
                 oa, ow, od, ea, ew, ed);
      end
    end
    tests_run++;
    if (n_rd[0] - b_rd[0] != 2 || sum4(n_rd) - sum4(b_rd) != 2 || n_ct[0] - b_ct[0] != 2
        || sum4(n_we) - sum4(b_we) != 0) begin
      fails++;
      $display("FAIL r2d_strobes: got rd0=%0d ct0=%0d we=%0d required 2 2 0",
               n_rd[0] - b_rd[0], n_ct[0] - b_ct[0], sum4(n_we) - sum4(b_we));
    end
    exp_addr.delete(); exp_we.delete(); exp_data.delete();
    probe(1'b1, a, ok);
    tests_run++;
    if (!ok || a !== 25'h40) begin
      fails++;
      $display("FAIL r2d_wa0_hold: got %h required 40", a);
    end
  endtask

  task automatic test_addi_zero();
    bit ok;
    logic [24:0] a;
    int b_we[4];
    load_reg(1'b0, 32'h20);
    ack_lat = 1;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(25'h20); exp_we.push_back(1'b0);
    end
    b_we = n_we;
    issue(1'b0, 2'd3, 1'b0, 3'd0, 1'b0, 8'd4);
    wait_idle(200, ok);
    tests_run++;
    if (!ok || obs_addr.size() != 4) begin
      fails++;
      $display("FAIL addi0_count: got %0d accesses (ok=%0d) required 4", obs_addr.size(), ok);
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [24:0] ea, oa;
      logic ew, ow;
      ea = exp_addr.pop_front(); ew = exp_we.pop_front();
      oa = obs_addr.pop_front(); ow = obs_we.pop_front();
      tests_run++;
      if (oa !== ea || ow !== ew) begin
        fails++;
        $display("FAIL addi0_access: got a=%h we=%b required a=%h we=%b", oa, ow, ea, ew);
      end
    end
    tests_run++;
    if (n_we[3] - b_we[3] != 4) begin
      fails++;
      $display("FAIL addi0_we3: got %0d required 4", n_we[3] - b_we[3]);
    end
    exp_addr.delete(); exp_we.delete();
    obs_data.delete(); obs_ramwd.delete();
    probe(1'b0, a, ok);
    tests_run++;
    if (!ok || a !== 25'h20) begin
      fails++;
      $display("FAIL addi0_ra0: got %h required 20", a);
    end
  endtask

  task automatic test_wrap_bypass();
    bit ok;
    logic [24:0] a;
    ack_lat = 0;
    exp_addr.push_back(25'h1FF_FFFF); exp_addr.push_back(25'h0);
    D1_DATA = 32'h01FF_FFFF;
    RA0_WE = 1'b1;
    issue(1'b0, 2'd1, 1'b0, 3'd1, 1'b0, 8'd2);
    RA0_WE = 1'b0;
    wait_idle(100, ok);
    tests_run++;
    if (!ok || obs_addr.size() != 2) begin
      fails++;
      $display("FAIL wrap_count: got %0d accesses (ok=%0d) required 2", obs_addr.size(), ok);
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [24:0] ea, oa;
      ea = exp_addr.pop_front(); oa = obs_addr.pop_front();
      tests_run++;
      if (oa !== ea) begin
        fails++;
        $display("FAIL wrap_access: got %h required %h", oa, ea);
      end
    end
    exp_addr.delete(); obs_we.delete(); obs_data.delete(); obs_ramwd.delete();
    probe(1'b0, a, ok);
    tests_run++;
    if (!ok || a !== 25'h1) begin
      fails++;
      $display("FAIL wrap_ra0: got %h required 1", a);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    logic [24:0] a;
    int b_done;
    load_reg(1'b0, 32'h10);
    ack_lat = 3;
    exp_addr.push_back(25'h10); exp_addr.push_back(25'h11);
    b_done = n_done;
    issue(1'b0, 2'd0, 1'b0, 3'd1, 1'b1, 8'd2);
    @(posedge CLK); #1;
    // Second command and an RA0 load while busy.
    D1_DATA = 32'h300; RA0_WE = 1'b1; DIR = 1'b1; CNT = 8'd5; START = 1'b1;
    @(posedge CLK); #1;
    RA0_WE = 1'b0; START = 1'b0; CE = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (D0_REQ !== 1'b1 || D0_ADDR !== 25'h10 || DONE !== 1'b0) begin
      fails++;
      $display("FAIL ce_freeze: got req=%b addr=%h done=%b required 1 10 0",
               D0_REQ, D0_ADDR, DONE);
    end
    @(posedge CLK); #1;
    CE = 1'b1;
    wait_idle(200, ok);
    tests_run++;
    if (!ok || obs_addr.size() != 2) begin
      fails++;
      $display("FAIL busy_count: got %0d accesses (ok=%0d) required 2", obs_addr.size(), ok);
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [24:0] ea, oa;
      ea = exp_addr.pop_front(); oa = obs_addr.pop_front();
      tests_run++;
      if (oa !== ea) begin
        fails++;
        $display("FAIL busy_access: got %h required %h", oa, ea);
      end
    end
    repeat (10) @(posedge CLK);
    #1;
    tests_run++;
    if (n_done - b_done != 1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_ignored: got done=%0d busy=%b required 1 0",
               n_done - b_done, BUSY);
    end
    exp_addr.delete(); obs_we.delete(); obs_data.delete(); obs_ramwd.delete();
    probe(1'b0, a, ok);
    tests_run++;
    if (!ok || a !== 25'h300) begin
      fails++;
      $display("FAIL busy_ra0_load: got %h required 300", a);
    end
  endtask

  task automatic test_prg_256();
    bit ok;
    int b_prg, b_busy, b_we[4], b_ct[4], bad_addr, n_rd_acc;
    ack_lat = 0;
    obs_prga.delete();
    b_prg = n_prg; b_busy = n_busy; b_we = n_we; b_ct = n_ct;
    issue(1'b0, 2'd1, 1'b1, 3'd1, 1'b1, 8'd0);
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || n_prg - b_prg != 256) begin
      fails++;
      $display("FAIL prg_count: got %0d PRG_WE (ok=%0d) required 256", n_prg - b_prg, ok);
    end
    bad_addr = 0;
    for (int i = 0; i < 256; i++) begin
      if (obs_prga.size() == 0 || obs_prga.pop_front() !== 8'(i)) bad_addr++;
    end
    tests_run++;
    if (bad_addr != 0) begin
      fails++;
      $display("FAIL prg_addr_seq: got %0d wrong addresses required 0", bad_addr);
    end
    tests_run++;
    if (sum4(n_we) - sum4(b_we) != 0 || sum4(n_ct) - sum4(b_ct) != 0) begin
      fails++;
      $display("FAIL prg_no_ram: got we=%0d ct=%0d required 0 0",
               sum4(n_we) - sum4(b_we), sum4(n_ct) - sum4(b_ct));
    end
    n_rd_acc = 0;
    while (obs_we.size() > 0) if (obs_we.pop_front() === 1'b0) n_rd_acc++;
    tests_run++;
    if (n_rd_acc != 256) begin
      fails++;
      $display("FAIL prg_d0_reads: got %0d required 256", n_rd_acc);
    end
    tests_run++;
    if (n_busy - b_busy < 513 || n_busy - b_busy > 800) begin
      fails++;
      $display("FAIL prg_busy_len: got %0d cycles required 513..800", n_busy - b_busy);
    end
    obs_addr.delete(); obs_data.delete(); obs_ramwd.delete(); obs_prga.delete();
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    logic [24:0] a;
    load_reg(1'b1, 32'h55);
    ack_lat = 1000;
    issue(1'b1, 2'd1, 1'b0, 3'd1, 1'b0, 8'd2);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (D0_REQ && D0_WE) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin
      fails++;
      $display("FAIL rst_reach_wr_d0: got no write request required one within 50 cycles");
    end
    RST_N = 1'b0;
    @(posedge CLK); #1;
    tests_run++;
    if (D0_REQ !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort: got req=%b busy=%b required 0 0", D0_REQ, BUSY);
    end
    RST_N = 1'b1;
    ack_lat = 0;
    @(posedge CLK); #1;
    tests_run++;
    if (obs_addr.size() != 0) begin
      fails++;
      $display("FAIL rst_no_access: got %0d completed accesses required 0", obs_addr.size());
    end
    probe(1'b1, a, ok);
    tests_run++;
    if (!ok || a !== 25'h0) begin
      fails++;
      $display("FAIL rst_wa0: got %h required 0", a);
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      n_we[b] = 0; n_rd[b] = 0; n_ct[b] = 0;
    end
    test_reset();
    test_d0_to_ram();
    test_ram_to_d0();
    test_addi_zero();
    test_wrap_bypass();
    test_busy_ignore();
    test_prg_256();
    test_reset_mid();
    tests_run++;
    if (n_bad != 0) begin
      fails++;
      $display("FAIL strobe_onehot: got %0d multi-hot cycles required 0", n_bad);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
